cdc_hs_src: RTL
===============

CDC_HS_SRC -- requirements
Module: cdc_hs_src

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the transferred data word.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the completed-transfer counter.
REQ-003 Port: clk_i  input  1  source-domain clock; sole clock of the block.
REQ-004 Port: rst_ni  input  1  asynchronous active-low reset.
REQ-005 Port: valid_i  input  1  upstream word valid.
REQ-006 Port: data_i  input  DATA_WIDTH  upstream word.
REQ-007 Port: ready_o  output  1  block can accept a word this cycle.
REQ-008 Port: req_o  output  1  4-phase request to the destination domain, registered.
REQ-009 Port: data_o  output  DATA_WIDTH  held word to the destination domain, registered.
REQ-010 Port: ack_i  input  1  asynchronous 4-phase acknowledge from the destination domain.
REQ-011 Port: busy_o  output  1  handshake in progress (state not IDLE).
REQ-012 Port: done_o  output  1  one-cycle pulse, destination has accepted the word.
REQ-013 Port: xfer_cnt_o  output  CNT_WIDTH  count of completed handshakes.

Function
REQ-014 ack_i SHALL pass through an internal two-flop synchronizer clocked by clk_i, reset to 0, before any use; the synchronized signal is ack_s.
REQ-015 FSM states SHALL be IDLE, REQ_HI, REQ_LO.
REQ-016 ready_o SHALL be combinational: 1 iff state==IDLE and ack_s==0.
REQ-017 IDLE: valid_i&&ready_o at edge N -> data_o<=data_i, req_o<=1, state<=REQ_HI; both visible after edge N.
REQ-018 REQ_HI: req_o held 1, data_o held stable; on ack_s==1 -> req_o<=0, state<=REQ_LO, done_o<=1 for exactly one cycle.
REQ-019 REQ_LO: req_o held 0, data_o held stable; on ack_s==0 -> state<=IDLE, xfer_cnt_o<=xfer_cnt_o+1.
REQ-020 data_o SHALL change only on an accepted word in IDLE; never while req_o or ack_s is 1.
REQ-021 valid_i while ready_o==0 SHALL be ignored; no capture, no state change.
REQ-022 IDLE with ack_s==1 (stale ack) SHALL hold ready_o=0 until ack_s returns to 0.
REQ-023 xfer_cnt_o SHALL wrap modulo 2^CNT_WIDTH without flag.
REQ-024 Minimum handshake: 1 accept cycle + ack round trip; accept-to-done latency = 1 + destination delay + 2 sync cycles minimum.
REQ-025 busy_o SHALL equal (state!=IDLE); done_o SHALL be registered.
REQ-026 Unused/illegal FSM encoding SHALL return to IDLE with req_o=0 on the next edge.

Reset
REQ-027 rst_ni low SHALL immediately force: state=IDLE, req_o=0, data_o=0, done_o=0, xfer_cnt_o=0, both sync flops=0.
REQ-028 Reset mid-handshake SHALL abort the transfer with no done_o pulse and no counter increment; after release, ready_o follows REQ-016/REQ-022.
REQ-029 Reset release SHALL be the only requirement on rst_ni timing; no synchronous reset path exists.

Verification
REQ-030 Single transfer: data_i=0xA5, valid_i 1 cycle, destination returns ack 3 cycles after req -> req_o rises after accept edge, done_o one pulse, data_o=0xA5 throughout, xfer_cnt_o=1.
REQ-031 Back-to-back: valid_i held high with 0x01,0x02,0x03 -> each word captured only in IDLE, data_o never changes while req_o|ack_s, xfer_cnt_o=3, three done_o pulses.
REQ-032 Stale ack: hold ack_i=1 across reset release -> ready_o=0, valid_i ignored until ack_i dropped and 2 cycles elapse; then ready_o=1.
REQ-033 Reset in REQ_HI: assert rst_ni low while req_o=1 -> req_o=0, data_o=0, busy_o=0 asynchronously, no done_o, xfer_cnt_o=0.
REQ-034 Counter wrap with CNT_WIDTH=2: five handshakes -> xfer_cnt_o sequence 1,2,3,0,1.
REQ-035 Ack glitch-free latency: ack_i rising asynchronously -> req_o falls no earlier than 2 and no later than 3 clk_i edges after the ack_i edge.

Source files
------------

// File: rtl/cdc_hs_src.sv
`default_nettype none
// ============================================================================
// cdc_hs_src : source side of a 4-phase req/ack CDC handshake with held data
// Revision   : 1.0
// ============================================================================
module cdc_hs_src #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  req_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ack_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_ack_meta;
   logic                  r_ack_s;
   logic                  r_req;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  w_ready;

   // ack_i is asynchronous to clk_i; only r_ack_s may be used by the FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= ack_i;
         r_ack_s    <= r_ack_meta;
      end
   end

   // A stale ack left over from before reset blocks new words until it clears
   assign w_ready = (r_state == IDLE) && !r_ack_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid_i && w_ready) begin
                  r_data  <= data_i;
                  r_req   <= 1'b1;
                  r_state <= REQ_HI;
               end
            end
            REQ_HI: begin
               if (r_ack_s) begin
                  r_req   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= REQ_LO;
               end
            end
            REQ_LO: begin
               if (!r_ack_s) begin
                  r_cnt   <= r_cnt + CNT_WIDTH'(1);
                  r_state <= IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready_o    = w_ready;
   assign req_o      = r_req;
   assign data_o     = r_data;
   assign busy_o     = (r_state != IDLE);
   assign done_o     = r_done;
   assign xfer_cnt_o = r_cnt;

endmodule
`default_nettype wire
